// File: rtl/versatile_fifo_rd_ctrl_if.sv
// rtl/versatile_fifo_rd_ctrl_if.sv - comparator, RAM and output-stream signals of the FIFO read end (rd_cnt with VERSATILE_FIFO_RD_CNT_EN)
interface versatile_fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] ram_adr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
`ifdef VERSATILE_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0]  rd_cnt;

    modport master (
        input  fifo_empty, ram_q, dout_ready,
        output rptr, ram_adr, ram_rd_en, dout, dout_valid, rd_cnt
    );

    modport slave (
        output fifo_empty, ram_q, dout_ready,
        input  rptr, ram_adr, ram_rd_en, dout, dout_valid, rd_cnt
    );
`else
    modport master (
        input  fifo_empty, ram_q, dout_ready,
        output rptr, ram_adr, ram_rd_en, dout, dout_valid
    );

    modport slave (
        output fifo_empty, ram_q, dout_ready,
        input  rptr, ram_adr, ram_rd_en, dout, dout_valid
    );
`endif
endinterface

// File: rtl/versatile_fifo_rd_ctrl.sv
// rtl/versatile_fifo_rd_ctrl.sv - FIFO read-end controller with gray pointer and 2-entry FWFT output (optional VERSATILE_FIFO_RD_CNT_EN)
module versatile_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    versatile_fifo_rd_ctrl_if.master bus
);

    logic [ADDR_WIDTH-1:0] rbin;
    logic [ADDR_WIDTH-1:0] rbin_next;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [1:0]            occ;
    logic [1:0]            credit;
    logic                  pop;
    logic                  rd_en;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  skid_valid_q;

    // Issue a RAM read whenever data exists and the output stage has room once this cycle's pop is counted.
    // rst_n gates the strobe so no read is requested while reset is held.
    always_comb begin
        pop       = dout_valid_q & bus.dout_ready;
        credit    = occ - {1'b0, pop};
        rd_en     = rst_n & ~bus.fifo_empty & (credit < 2'd2);
        rbin_next = rbin + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    // Binary read pointer and its registered gray image; the gray code changes one bit per step for the comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin   <= '0;
            rptr_q <= '0;
        end else if (rd_en) begin
            rbin   <= rbin_next;
            rptr_q <= rbin_next ^ (rbin_next >> 1);
        end
    end

    // Occupancy: words held in dout/skid plus the word returning from the RAM this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, rd_en} - {1'b0, pop};
        end
    end

    // Output stage: RAM data lands in dout when it is free or leaving, otherwise in the skid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (pop) begin
                if (skid_valid_q) begin
                    dout_q <= skid_q;
                    if (inflight) begin
                        skid_q <= bus.ram_q;
                    end else begin
                        skid_valid_q <= 1'b0;
                    end
                end else if (inflight) begin
                    dout_q <= bus.ram_q;
                end else begin
                    dout_valid_q <= 1'b0;
                end
            end else if (inflight) begin
                if (!dout_valid_q) begin
                    dout_q       <= bus.ram_q;
                    dout_valid_q <= 1'b1;
                end else begin
                    skid_q       <= bus.ram_q;
                    skid_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef VERSATILE_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Count of words handed to the sink, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.rd_cnt = cnt_q;
`endif

    assign bus.rptr       = rptr_q;
    assign bus.ram_adr    = rbin;
    assign bus.ram_rd_en  = rd_en;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_versatile_fifo_rd_ctrl.sv
// tb/tb_versatile_fifo_rd_ctrl.sv - directed self-checking bench for versatile_fifo_rd_ctrl
module tb_versatile_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    versatile_fifo_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    versatile_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:15];
    int wr_total = 0;
    int rd_issued;
    int checks = 0;
    int failures = 0;

    assign bus.fifo_empty = (rd_issued == wr_total);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_issued <= 0;
            bus.ram_q <= '0;
        end else if (bus.ram_rd_en) begin
            rd_issued <= rd_issued + 1;
            bus.ram_q <= mem[bus.ram_adr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_total = 0;
        bus.dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_a();
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    endtask

    task automatic test_reset();
        do_reset();
        mem[0] = 8'h5A; mem[1] = 8'h5B;
        wr_total = 2;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_valid got=%b exp=1", bus.dout_valid); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        wr_total = 0;
        #1;
        checks++;
        if (bus.rptr !== 4'd0) begin failures++; $display("FAIL reset_rptr got=%0h exp=0", bus.rptr); end
        checks++;
        if (bus.ram_adr !== 4'd0) begin failures++; $display("FAIL reset_ram_adr got=%0h exp=0", bus.ram_adr); end
        checks++;
        if (bus.ram_rd_en !== 1'b0) begin failures++; $display("FAIL reset_ram_rd_en got=%b exp=0", bus.ram_rd_en); end
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h exp=0", bus.dout); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int exp_rptr [7] = '{0, 1, 3, 2, 6, 6, 6};
        int exp_v    [7] = '{0, 0, 1, 1, 1, 1, 0};
        int exp_en   [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [DW-1:0] exp_d;
        do_reset();
        load_a();
        bus.dout_ready = 1'b1;
        @(negedge clk);
        wr_total = 4;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (int'(bus.rptr) != exp_rptr[k]) begin failures++; $display("FAIL stream_rptr k=%0d got=%0d exp=%0d", k, bus.rptr, exp_rptr[k]); end
            checks++;
            if (int'(bus.dout_valid) != exp_v[k]) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=%0d", k, bus.dout_valid, exp_v[k]); end
            checks++;
            if (int'(bus.ram_rd_en) != exp_en[k]) begin failures++; $display("FAIL stream_rd_en k=%0d got=%b exp=%0d", k, bus.ram_rd_en, exp_en[k]); end
            if (k >= 2 && k <= 5) begin
                exp_d = 8'(8'hA0 + k - 2);
                checks++;
                if (bus.dout !== exp_d) begin failures++; $display("FAIL stream_dout k=%0d got=%0h exp=%0h", k, bus.dout, exp_d); end
            end
        end
    endtask

    task automatic test_backpressure();
        int en_cnt = 0;
        int npop = 0;
        int last_r = -1;
        logic [DW-1:0] exp_d;
        do_reset();
        load_a();
        @(negedge clk);
        wr_total = 4;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.ram_rd_en) en_cnt++;
            if (c >= 2) begin
                checks++;
                if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA0) begin
                    failures++;
                    $display("FAIL bp_hold c=%0d got=%b/%0h exp=1/a0", c, bus.dout_valid, bus.dout);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (en_cnt != 2) begin failures++; $display("FAIL bp_rd_en_pulses got=%0d exp=2", en_cnt); end
        bus.dout_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            #1;
            if (bus.dout_valid) begin
                exp_d = 8'(8'hA0 + npop);
                checks++;
                if (bus.dout !== exp_d) begin failures++; $display("FAIL bp_dout n=%0d got=%0h exp=%0h", npop, bus.dout, exp_d); end
                if (last_r >= 0) begin
                    checks++;
                    if (r - last_r > 2) begin failures++; $display("FAIL bp_gap n=%0d got=%0d exp<=2", npop, r - last_r); end
                end
                last_r = r;
                npop++;
            end
            @(negedge clk);
        end
        checks++;
        if (npop != 4) begin failures++; $display("FAIL bp_pop_count got=%0d exp=4", npop); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] prev_rptr;
        logic [AW-1:0] prev_adr;
        logic [DW-1:0] exp_d;
        logic [3:0]    widx;
        int npop = 0;
        bit saw_wrap = 0;
        do_reset();
        bus.dout_ready = 1'b1;
        prev_rptr = bus.rptr;
        prev_adr = bus.ram_adr;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) begin
                widx = c[3:0];
                mem[widx] = 8'(8'h40 + c);
                wr_total++;
            end
            #1;
            checks++;
            if ($countones(bus.rptr ^ prev_rptr) > 1) begin
                failures++;
                $display("FAIL wrap_gray_step c=%0d got=%0h prev=%0h exp_dist<=1", c, bus.rptr, prev_rptr);
            end
            if (prev_adr == 4'd15 && bus.ram_adr == 4'd0) saw_wrap = 1;
            prev_rptr = bus.rptr;
            prev_adr = bus.ram_adr;
            if (bus.dout_valid) begin
                exp_d = 8'(8'h40 + npop);
                checks++;
                if (bus.dout !== exp_d) begin failures++; $display("FAIL wrap_dout n=%0d got=%0h exp=%0h", npop, bus.dout, exp_d); end
                npop++;
            end
            @(negedge clk);
        end
        checks++;
        if (npop != 20) begin failures++; $display("FAIL wrap_pop_count got=%0d exp=20", npop); end
        checks++;
        if (!saw_wrap) begin failures++; $display("FAIL wrap_adr_15_to_0 got=0 exp=1"); end
        checks++;
        if (bus.rptr !== 4'd6) begin failures++; $display("FAIL wrap_final_rptr got=%0h exp=6", bus.rptr); end
        checks++;
        if (bus.ram_adr !== 4'd4) begin failures++; $display("FAIL wrap_final_adr got=%0h exp=4", bus.ram_adr); end
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        do_reset();
        load_a();
        @(negedge clk);
        wr_total = 4;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", bus.dout_valid); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        wr_total = 0;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL mid_dout_valid got=%b exp=0", bus.dout_valid); end
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL mid_dout got=%0h exp=0", bus.dout); end
        checks++;
        if (bus.rptr !== 4'd0 || bus.ram_adr !== 4'd0) begin failures++; $display("FAIL mid_ptr got=%0h/%0h exp=0/0", bus.rptr, bus.ram_adr); end
        @(negedge clk);
        rst_n = 1'b1;
        mem[0] = 8'h11; mem[1] = 8'h22;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        wr_total = 2;
        #1;
        checks++;
        if (bus.ram_rd_en !== 1'b1 || bus.ram_adr !== 4'd0) begin
            failures++;
            $display("FAIL mid_first_read got=%b@%0h exp=1@0", bus.ram_rd_en, bus.ram_adr);
        end
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.dout_valid) begin
                got = 1;
                checks++;
                if (bus.dout !== 8'h11) begin failures++; $display("FAIL mid_first_word got=%0h exp=11", bus.dout); end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL mid_first_word_timeout got=none exp=11");
        end
    endtask

`ifdef VERSATILE_FIFO_RD_CNT_EN
    task automatic stream_words(input int n);
        logic [3:0] widx;
        for (int i = 0; i < n; i++) begin
            widx = wr_total[3:0];
            mem[widx] = 8'(i);
            wr_total++;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_rd_cnt();
        do_reset();
        checks++;
        if (bus.rd_cnt !== 8'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", bus.rd_cnt); end
        bus.dout_ready = 1'b1;
        stream_words(37);
        checks++;
        if (bus.rd_cnt !== 8'd37) begin failures++; $display("FAIL cnt_37 got=%0d exp=37", bus.rd_cnt); end
        stream_words(220);
        checks++;
        if (bus.rd_cnt !== 8'd1) begin failures++; $display("FAIL cnt_wrap got=%0d exp=1", bus.rd_cnt); end
    endtask
`endif

    initial begin
        bus.dout_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef VERSATILE_FIFO_RD_CNT_EN
        test_rd_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
